// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer sitting between the MIPS core data port and data RAM.
// Claims a 16-byte window, muxes its registers onto the read path and raises a level irq on expiry.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  input  logic [31:0] ram_readdata,
  output logic        ram_we,
  output logic [31:0] memreaddata,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic          en_reg, en_next;
  logic          autoreload_reg, autoreload_next;
  logic          irqen_reg, irqen_next;
  logic          expired_reg, expired_next;
  logic [31:0]   load_reg, load_next;
  logic [31:0]   count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next;

  logic          hit;
  logic [1:0]    sel;
  logic          wr_ctrl, wr_load, wr_count, wr_status;
  logic          tick, tick_eff;
  logic [31:0]   reg_rdata;
  logic          unused_addr_bits;

  // Reset masks the decode so the core sees plain RAM while the timer is held.
  assign hit              = (memaddr[31:4] == BASE_ADDR[31:4]) & ~reset;
  assign sel              = memaddr[3:2];
  assign unused_addr_bits = ^memaddr[1:0];

  assign wr_ctrl   = memwrite & hit & (sel == 2'd0);
  assign wr_load   = memwrite & hit & (sel == 2'd1);
  assign wr_count  = memwrite & hit & (sel == 2'd2);
  assign wr_status = memwrite & hit & (sel == 2'd3);

  assign tick     = en_reg & (presc_reg == PRESC_MAX);
  // A CPU write to CTRL or COUNT on a tick edge takes priority and the tick is lost.
  assign tick_eff = tick & ~wr_ctrl & ~wr_count;

  always_comb begin
    en_next         = en_reg;
    autoreload_next = autoreload_reg;
    irqen_next      = irqen_reg;
    expired_next    = expired_reg;
    load_next       = load_reg;
    count_next      = count_reg;
    presc_next      = presc_reg;

    if (!en_reg || tick) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + 1'b1;
    end

    // Clear is applied before expiry so a simultaneous expiry leaves the flag set.
    if (wr_status && memwritedata[0]) begin
      expired_next = 1'b0;
    end

    if (tick_eff) begin
      if (count_reg != 32'd0) begin
        count_next = count_reg - 32'd1;
      end else begin
        expired_next = 1'b1;
        if (autoreload_reg) begin
          count_next = load_reg;
        end else begin
          en_next = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      en_next         = memwritedata[0];
      autoreload_next = memwritedata[1];
      irqen_next      = memwritedata[2];
      presc_next      = '0;
    end

    if (wr_count) begin
      count_next = memwritedata;
      presc_next = '0;
    end

    // Reload above reads load_reg, so a same-cycle LOAD write only affects the next reload.
    if (wr_load) begin
      load_next = memwritedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_reg         <= 1'b0;
      autoreload_reg <= 1'b0;
      irqen_reg      <= 1'b0;
      expired_reg    <= 1'b0;
      load_reg       <= 32'd0;
      count_reg      <= 32'd0;
      presc_reg      <= '0;
    end else begin
      en_reg         <= en_next;
      autoreload_reg <= autoreload_next;
      irqen_reg      <= irqen_next;
      expired_reg    <= expired_next;
      load_reg       <= load_next;
      count_reg      <= count_next;
      presc_reg      <= presc_next;
    end
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (sel)
      2'd0:    reg_rdata = {29'd0, irqen_reg, autoreload_reg, en_reg};
      2'd1:    reg_rdata = load_reg;
      2'd2:    reg_rdata = count_reg;
      default: reg_rdata = {31'd0, expired_reg};
    endcase
  end

  assign memreaddata = hit ? reg_rdata : ram_readdata;
  assign ram_we      = memwrite & ~hit;
  assign irq         = expired_reg & irqen_reg;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset, pass-through, one-shot, autoreload, collisions and decode.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_mmio_timer;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] ram_readdata;
  logic        ram_we;
  logic [31:0] memreaddata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_CTRL   = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;
  localparam logic [31:0] A_RAM    = 32'h0000_0040;

  mmio_timer dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .ram_readdata (ram_readdata),
    .ram_we       (ram_we),
    .memreaddata  (memreaddata),
    .irq          (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge and the task returns at the following falling edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memwrite     = 1'b1;
    memaddr      = addr;
    memwritedata = data;
    @(negedge clk);
    memwrite     = 1'b0;
    memaddr      = A_RAM;
    memwritedata = 32'd0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memaddr = addr;
    #1;
    chk(tag, memreaddata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = A_COUNT;
    memwritedata = 32'd0;
    ram_readdata = 32'hA5A5_0000;

    // While in reset the window is transparent.
    cyc(2);
    #1;
    chk("rst_rdata_passthru", memreaddata, 32'hA5A5_0000);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    memwrite = 1'b1;
    #1;
    chk("rst_ram_we", {31'd0, ram_we}, 32'd1);
    memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    rd("reset_ctrl",   A_CTRL,   32'd0);
    rd("reset_load",   A_LOAD,   32'd0);
    rd("reset_count",  A_COUNT,  32'd0);
    rd("reset_status", A_STATUS, 32'd0);
    @(negedge clk);

    // Pass-through to RAM, then a store that the timer claims.
    ram_readdata = 32'hDEAD_BEEF;
    memwrite     = 1'b1;
    memaddr      = A_RAM;
    memwritedata = 32'h1111_2222;
    #1;
    chk("ram_we_outside", {31'd0, ram_we}, 32'd1);
    chk("ram_rdata_outside", memreaddata, 32'hDEAD_BEEF);
    memaddr      = A_LOAD;
    memwritedata = 32'h1234_5678;
    #1;
    chk("ram_we_suppressed", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    memwrite = 1'b0;
    rd("load_written", A_LOAD, 32'h1234_5678);

    // One-shot: COUNT=3, CTRL=en|irqen -> expiry 16 clocks after the enabling edge.
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h5);
    cyc(3);
    rd("oneshot_count_k3", A_COUNT, 32'd3);
    cyc(1);
    rd("oneshot_count_k4", A_COUNT, 32'd2);
    cyc(11);
    #1;
    chk("oneshot_irq_k15", {31'd0, irq}, 32'd0);
    rd("oneshot_status_k15", A_STATUS, 32'd0);
    cyc(1);
    #1;
    chk("oneshot_irq_k16", {31'd0, irq}, 32'd1);
    rd("oneshot_status_k16", A_STATUS, 32'd1);
    rd("oneshot_ctrl_after", A_CTRL, 32'h4);
    rd("oneshot_count_after", A_COUNT, 32'd0);
    cyc(3);
    rd("oneshot_count_stays", A_COUNT, 32'd0);
    #1;
    chk("oneshot_irq_held", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-count clears everything without a clock edge.
    @(negedge clk);
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h5);
    cyc(2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd("async_rst_ctrl",   A_CTRL,   32'd0);
    rd("async_rst_load",   A_LOAD,   32'd0);
    rd("async_rst_count",  A_COUNT,  32'd0);
    rd("async_rst_status", A_STATUS, 32'd0);
    @(negedge clk);

    // Autoreload with LOAD=2: expiry on tick 1, then every third tick (ticks every 4 clocks).
    wr(A_LOAD, 32'd2);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h3);
    cyc(3);
    rd("auto_status_k3", A_STATUS, 32'd0);
    cyc(1);
    rd("auto_status_k4", A_STATUS, 32'd1);
    rd("auto_count_k4", A_COUNT, 32'd2);
    #1;
    chk("auto_irq_masked", {31'd0, irq}, 32'd0);
    wr(A_STATUS, 32'd1);
    rd("auto_w1c_k5", A_STATUS, 32'd0);
    cyc(10);
    rd("auto_status_k15", A_STATUS, 32'd0);
    cyc(1);
    rd("auto_status_k16", A_STATUS, 32'd1);
    rd("auto_count_k16", A_COUNT, 32'd2);

    // W1C on the expiry edge: set wins.
    wr(A_STATUS, 32'd1);
    rd("auto_w1c_k17", A_STATUS, 32'd0);
    cyc(10);
    wr(A_STATUS, 32'd1);
    rd("collide_w1c_expiry", A_STATUS, 32'd1);
    rd("collide_reload_count", A_COUNT, 32'd2);

    // COUNT write on a tick edge: write wins, tick dropped.
    cyc(3);
    wr(A_COUNT, 32'd7);
    rd("collide_count_write", A_COUNT, 32'd7);
    cyc(3);
    rd("after_collide_k35", A_COUNT, 32'd7);
    cyc(1);
    rd("after_collide_k36", A_COUNT, 32'd6);

    // Decode boundaries.
    rd("decode_next_window", 32'hFFFF_0013, 32'hDEAD_BEEF);
    rd("decode_unaligned_count", 32'hFFFF_000B, 32'd6);
    rd("decode_ctrl_alias", 32'hFFFF_0001, 32'h3);

    // Undefined CTRL bits read 0; disabling freezes the count.
    @(negedge clk);
    wr(A_CTRL, 32'hFFFF_FFF8);
    rd("ctrl_upper_bits", A_CTRL, 32'd0);
    rd("frozen_count_a", A_COUNT, 32'd6);
    cyc(9);
    rd("frozen_count_b", A_COUNT, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
